pc_redirect_ctrl: RTL and testbench
===================================

Name: pc_redirect_ctrl

Overview:
- Front-end controller that sequences the PC register.
- Arbitrates three redirect sources into the single `pc_sel`/`branch_target` pair the PC register consumes:
  - trap
  - EX-stage branch resolve
  - ID-stage jump
- Also generates the PC advance enable and the IF/ID flush strobes.
- Holds a redirect that arrives during a pipeline stall and replays it when the stall clears.

Parameters:
- XLEN, 32, PC/target width in bits
- CNT_W, 16, width of redirect performance counter (used only with REDIRECT_CNT_EN)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- stall  in  1  hazard unit requests PC/IF hold
- trap_valid  in  1  trap/exception redirect request
- trap_target  in  XLEN  trap vector
- ex_redir_valid  in  1  EX branch mispredict/taken redirect
- ex_redir_target  in  XLEN  EX redirect target
- id_redir_valid  in  1  ID unconditional jump redirect
- id_redir_target  in  XLEN  ID redirect target
- pc_en  out  1  PC register may update this edge
- pc_sel  out  1  0 = PC+4, 1 = branch_target
- branch_target  out  XLEN  selected redirect target, bits[1:0] forced 0
- flush_if  out  1  kill IF/ID pipeline register contents
- flush_id  out  1  kill ID/EX pipeline register contents
- misalign  out  1  one-cycle pulse: selected target had bits[1:0] != 0
- pending  out  1  a redirect is held awaiting stall release
- redir_count  out  CNT_W  redirects applied (REDIRECT_CNT_EN only)

Behaviour:
- Source priority, highest first: trap > held pending redirect > EX > ID.
  - The pending redirect outranks new EX/ID requests because it belongs to an older instruction.
- FSM states: RUN, HOLD_EMPTY, HOLD_PEND.
  - Reset enters RUN.
  - Pending register is cleared on reset.
- Outputs after reset: pc_en=1, pc_sel=0, branch_target=0, flush_if=0, flush_id=0, misalign=0, pending=0, redir_count=0.
- RUN state, stall=0:
  - pc_en=1.
  - If any source is valid, the winner drives pc_sel=1 and branch_target combinationally in the same cycle (zero latency; the PC loads it on the next edge).
  - Otherwise pc_sel=0.
- Flush rules, whenever a redirect is applied:
  - flush_if=1.
  - flush_id=1 if the winner is trap or EX.
  - A pending redirect reuses the flush_id value captured with it.
- RUN state, stall=1:
  - pc_en=0, pc_sel=0, no flush.
  - Any valid source is captured (target plus source class) into the pending register; next state is HOLD_PEND.
  - With no source valid, next state is HOLD_EMPTY.
- HOLD_EMPTY:
  - pc_en=0 while stall=1.
  - A valid source arriving captures into pending → HOLD_PEND.
  - stall=0 → behave exactly as RUN this cycle → RUN.
- HOLD_PEND:
  - pc_en=0 while stall=1.
  - A new trap overwrites pending.
  - New EX/ID requests are ignored (older pending wins).
  - stall=0:
    - Apply pending: pc_sel=1, branch_target=held target, flush per captured class.
    - Clear pending → RUN.
    - A simultaneous trap_valid wins over pending; pending is discarded.
- Trap while stall=1 is still captured, never applied during the stall.
- misalign: pulses in the cycle a redirect is applied if the raw target had [1:0] != 0; the target is still applied with [1:0]=0.
- Reset asserted mid-HOLD_PEND: pending is dropped, state returns to RUN, no redirect is emitted.
- pc_sel is never X: 0 whenever no redirect is applied.

Optional Feature:
- Macro: REDIRECT_CNT_EN.
- Defined:
  - redir_count increments by 1 on each cycle with pc_sel=1 and pc_en=1.
  - Wraps modulo 2^CNT_W.
  - Reset to 0.
- Undefined:
  - Counter logic is not instantiated.
  - redir_count is tied to 0.

Test Plan:
- Reset, then no requests for 4 cycles -> pc_en=1, pc_sel=0, flushes 0, pending=0 every cycle.
- RUN, ex_redir_valid=1 target 0x0000_0100 alongside id_redir_valid=1 target 0x0000_0200 -> same cycle pc_sel=1, branch_target=0x100, flush_if=1, flush_id=1.
- stall=1 for 3 cycles, id_redir_valid pulse target 0x40 in cycle 1, then ex_redir_valid target 0x80 in cycle 2 -> pending=1, pc_en=0, pc_sel=0 during stall; first cycle after stall drop: pc_sel=1, branch_target=0x40, flush_if=1, flush_id=0; next cycle pending=0, pc_sel=0.
- HOLD_PEND (target 0x40), trap_valid target 0x1000 in the same cycle stall drops -> branch_target=0x1000, flush_id=1, pending cleared.
- ex_redir_target 0x0000_0103 in RUN -> branch_target=0x100, misalign=1 for exactly one cycle.
- HOLD_PEND then rst=1 for 1 cycle, stall=0 afterwards -> no pc_sel pulse, pending=0; with REDIRECT_CNT_EN, 3 applied redirects -> redir_count=3, and the count wraps to 0 after 2^CNT_W applied redirects.

Source files
------------

// File: rtl/pc_redirect_ctrl_if.sv
// Redirect-controller bundle: hazard/redirect requests in, PC/flush controls out.
// The redir_count member is only driven by a live counter when REDIRECT_CNT_EN is defined.
interface pc_redirect_ctrl_if #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned CNT_W = 16
) ();
   logic             stall;
   logic             trap_valid;
   logic [XLEN-1:0]  trap_target;
   logic             ex_redir_valid;
   logic [XLEN-1:0]  ex_redir_target;
   logic             id_redir_valid;
   logic [XLEN-1:0]  id_redir_target;
   logic             pc_en;
   logic             pc_sel;
   logic [XLEN-1:0]  branch_target;
   logic             flush_if;
   logic             flush_id;
   logic             misalign;
   logic             pending;
   logic [CNT_W-1:0] redir_count;

   modport master (
      output stall, trap_valid, trap_target, ex_redir_valid, ex_redir_target,
             id_redir_valid, id_redir_target,
      input  pc_en, pc_sel, branch_target, flush_if, flush_id, misalign,
             pending, redir_count
   );

   modport slave (
      input  stall, trap_valid, trap_target, ex_redir_valid, ex_redir_target,
             id_redir_valid, id_redir_target,
      output pc_en, pc_sel, branch_target, flush_if, flush_id, misalign,
             pending, redir_count
   );
endinterface

// File: rtl/pc_redirect_ctrl.sv
// PC redirect arbiter (trap > held pending > EX > ID) with stall capture/replay.
// Optional macro REDIRECT_CNT_EN adds a wrapping applied-redirect counter on redir_count.
module pc_redirect_ctrl #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned CNT_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   pc_redirect_ctrl_if.slave ctrl
);
   typedef enum logic [1:0] {
      RUN        = 2'd0,
      HOLD_EMPTY = 2'd1,
      HOLD_PEND  = 2'd2
   } state_e;

   state_e          state_q, state_d;
   logic [XLEN-1:0] pend_target_q, pend_target_d;
   logic            pend_flush_id_q, pend_flush_id_d;

   logic            req_valid;
   logic [XLEN-1:0] req_target;
   logic            req_flush_id;

   logic            apply;
   logic [XLEN-1:0] apply_raw;
   logic            apply_flush_id;
   logic            pc_en_c;

   // Fresh-request arbitration among the live sources: trap > EX > ID
   always_comb begin
      req_valid    = ctrl.trap_valid | ctrl.ex_redir_valid | ctrl.id_redir_valid;
      req_target   = '0;
      req_flush_id = 1'b0;
      if (ctrl.trap_valid) begin
         req_target   = ctrl.trap_target;
         req_flush_id = 1'b1;
      end else if (ctrl.ex_redir_valid) begin
         req_target   = ctrl.ex_redir_target;
         req_flush_id = 1'b1;
      end else if (ctrl.id_redir_valid) begin
         req_target   = ctrl.id_redir_target;
         req_flush_id = 1'b0;
      end
   end

   always_comb begin
      state_d         = state_q;
      pend_target_d   = pend_target_q;
      pend_flush_id_d = pend_flush_id_q;
      apply           = 1'b0;
      apply_raw       = '0;
      apply_flush_id  = 1'b0;
      pc_en_c         = 1'b1;

      unique case (state_q)
         RUN, HOLD_EMPTY: begin
            if (ctrl.stall) begin
               pc_en_c = 1'b0;
               if (req_valid) begin
                  pend_target_d   = req_target;
                  pend_flush_id_d = req_flush_id;
                  state_d         = HOLD_PEND;
               end else begin
                  state_d = HOLD_EMPTY;
               end
            end else begin
               state_d        = RUN;
               apply          = req_valid;
               apply_raw      = req_target;
               apply_flush_id = req_flush_id;
            end
         end
         HOLD_PEND: begin
            if (ctrl.stall) begin
               pc_en_c = 1'b0;
               // Only a trap may displace the older held redirect
               if (ctrl.trap_valid) begin
                  pend_target_d   = ctrl.trap_target;
                  pend_flush_id_d = 1'b1;
               end
            end else begin
               state_d         = RUN;
               apply           = 1'b1;
               pend_target_d   = '0;
               pend_flush_id_d = 1'b0;
               if (ctrl.trap_valid) begin
                  apply_raw      = ctrl.trap_target;
                  apply_flush_id = 1'b1;
               end else begin
                  apply_raw      = pend_target_q;
                  apply_flush_id = pend_flush_id_q;
               end
            end
         end
         default: state_d = RUN;
      endcase

      // Reset cycle emits no redirect regardless of held state
      if (rst) begin
         apply          = 1'b0;
         apply_raw      = '0;
         apply_flush_id = 1'b0;
         pc_en_c        = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= RUN;
         pend_target_q   <= '0;
         pend_flush_id_q <= 1'b0;
      end else begin
         state_q         <= state_d;
         pend_target_q   <= pend_target_d;
         pend_flush_id_q <= pend_flush_id_d;
      end
   end

   assign ctrl.pc_en         = pc_en_c;
   assign ctrl.pc_sel        = apply;
   assign ctrl.branch_target = apply ? {apply_raw[XLEN-1:2], 2'b00} : '0;
   assign ctrl.flush_if      = apply;
   assign ctrl.flush_id      = apply & apply_flush_id;
   assign ctrl.misalign      = apply & (|apply_raw[1:0]);
   assign ctrl.pending       = (state_q == HOLD_PEND) & ~rst;

`ifdef REDIRECT_CNT_EN
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (apply && pc_en_c) cnt_d = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign ctrl.redir_count = cnt_q;
`else
   assign ctrl.redir_count = CNT_W'(0);
`endif
endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Bench for pc_redirect_ctrl: per-cycle reference model (single optional held redirect)
// plus directed literal checks; counter expectations follow REDIRECT_CNT_EN.
module tb_pc_redirect_ctrl;
   localparam int unsigned XLEN  = 32;
   localparam int unsigned CNT_W = 16;

   logic clk;
   logic rst;
   logic chk_en;
   int   n_cmp;
   int   n_bad;

   pc_redirect_ctrl_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

   pc_redirect_ctrl #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
      .clk  (clk),
      .rst  (rst),
      .ctrl (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
      end
   endtask

   // Reference model: at most one held redirect, plus an applied-redirect tally
   logic             m_held;
   logic [XLEN-1:0]  m_ht;
   logic             m_hf;
   logic [CNT_W-1:0] m_cnt;

   always @(negedge clk) begin
      logic            e_en, e_pend, app, fid;
      logic [XLEN-1:0] raw, e_bt;
      logic [CNT_W-1:0] e_cnt;
      if (chk_en) begin
         e_en = 1'b1; app = 1'b0; fid = 1'b0; raw = '0; e_pend = 1'b0;
`ifdef REDIRECT_CNT_EN
         e_cnt = m_cnt;
`else
         e_cnt = '0;
`endif
         if (rst) begin
            m_held = 1'b0;
            m_cnt  = '0;
         end else begin
            e_pend = m_held;
            if (bus.stall) begin
               e_en = 1'b0;
               if (bus.trap_valid) begin
                  m_held = 1'b1; m_ht = bus.trap_target; m_hf = 1'b1;
               end else if (!m_held && bus.ex_redir_valid) begin
                  m_held = 1'b1; m_ht = bus.ex_redir_target; m_hf = 1'b1;
               end else if (!m_held && bus.id_redir_valid) begin
                  m_held = 1'b1; m_ht = bus.id_redir_target; m_hf = 1'b0;
               end
            end else begin
               if (bus.trap_valid) begin
                  app = 1'b1; raw = bus.trap_target; fid = 1'b1;
               end else if (m_held) begin
                  app = 1'b1; raw = m_ht; fid = m_hf;
               end else if (bus.ex_redir_valid) begin
                  app = 1'b1; raw = bus.ex_redir_target; fid = 1'b1;
               end else if (bus.id_redir_valid) begin
                  app = 1'b1; raw = bus.id_redir_target; fid = 1'b0;
               end
               m_held = 1'b0;
               if (app) m_cnt = m_cnt + 1'b1;
            end
         end
         e_bt = app ? (raw & ~32'h3) : '0;
         check("pc_en",         32'(bus.pc_en),         32'(e_en));
         check("pc_sel",        32'(bus.pc_sel),        32'(app));
         check("branch_target", bus.branch_target,      e_bt);
         check("flush_if",      32'(bus.flush_if),      32'(app));
         check("flush_id",      32'(bus.flush_id),      32'(app & fid));
         check("misalign",      32'(bus.misalign),      32'(app && (raw % 4 != 0)));
         check("pending",       32'(bus.pending),       32'(e_pend));
         check("redir_count",   32'(bus.redir_count),   32'(e_cnt));
      end
   end

   task automatic set_in(input logic s, input logic tv, input logic [31:0] tt,
                         input logic ev, input logic [31:0] et,
                         input logic iv, input logic [31:0] it);
      bus.stall = s;
      bus.trap_valid = tv;     bus.trap_target = tt;
      bus.ex_redir_valid = ev; bus.ex_redir_target = et;
      bus.id_redir_valid = iv; bus.id_redir_target = it;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_cmp = 0; n_bad = 0; chk_en = 1'b0;
      m_held = 1'b0; m_ht = '0; m_hf = 1'b0; m_cnt = '0;
      rst = 1'b1;
      set_in(0, 0, 0, 0, 0, 0, 0);
      next_cycle();
      chk_en = 1'b1;
      next_cycle();
      rst = 1'b0;

      // Idle after reset
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("idle pc_en",   32'(bus.pc_en),   32'd1);
         check("idle pc_sel",  32'(bus.pc_sel),  32'd0);
         check("idle flush",   32'({bus.flush_if, bus.flush_id}), 32'd0);
         check("idle pending", 32'(bus.pending), 32'd0);
         next_cycle();
      end

      // EX beats ID, zero latency
      set_in(0, 0, 0, 1, 32'h100, 1, 32'h200);
      @(negedge clk);
      check("exid pc_sel", 32'(bus.pc_sel),   32'd1);
      check("exid target", bus.branch_target, 32'h100);
      check("exid fif",    32'(bus.flush_if), 32'd1);
      check("exid fid",    32'(bus.flush_id), 32'd1);
      next_cycle();

      // Stall capture of ID, later EX ignored, replay on release
      set_in(1, 0, 0, 0, 0, 1, 32'h40);
      @(negedge clk);
      check("st1 pc_en",  32'(bus.pc_en),  32'd0);
      check("st1 pc_sel", 32'(bus.pc_sel), 32'd0);
      next_cycle();
      set_in(1, 0, 0, 1, 32'h80, 0, 0);
      @(negedge clk);
      check("st2 pending", 32'(bus.pending), 32'd1);
      check("st2 pc_en",   32'(bus.pc_en),   32'd0);
      check("st2 pc_sel",  32'(bus.pc_sel),  32'd0);
      next_cycle();
      set_in(1, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      check("st3 pending", 32'(bus.pending), 32'd1);
      next_cycle();
      set_in(0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      check("rel pc_sel", 32'(bus.pc_sel),   32'd1);
      check("rel target", bus.branch_target, 32'h40);
      check("rel fif",    32'(bus.flush_if), 32'd1);
      check("rel fid",    32'(bus.flush_id), 32'd0);
      next_cycle();
      @(negedge clk);
      check("post pending", 32'(bus.pending), 32'd0);
      check("post pc_sel",  32'(bus.pc_sel),  32'd0);
      next_cycle();

      // Trap on release outranks held redirect
      set_in(1, 0, 0, 0, 0, 1, 32'h40);
      next_cycle();
      set_in(0, 1, 32'h1000, 0, 0, 0, 0);
      @(negedge clk);
      check("trap target", bus.branch_target, 32'h1000);
      check("trap fid",    32'(bus.flush_id), 32'd1);
      next_cycle();
      set_in(0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      check("trap pending", 32'(bus.pending), 32'd0);
      next_cycle();

      // Misaligned target
      set_in(0, 0, 0, 1, 32'h103, 0, 0);
      @(negedge clk);
      check("mis target", bus.branch_target, 32'h100);
      check("mis pulse",  32'(bus.misalign), 32'd1);
      next_cycle();
      set_in(0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      check("mis drop", 32'(bus.misalign), 32'd0);
      next_cycle();

      // Reset while holding drops the pending redirect
      set_in(1, 0, 0, 0, 0, 1, 32'h40);
      next_cycle();
      set_in(0, 0, 0, 0, 0, 0, 0);
      rst = 1'b1;
      @(negedge clk);
      check("rst pc_sel", 32'(bus.pc_sel), 32'd0);
      next_cycle();
      rst = 1'b0;
      @(negedge clk);
      check("rst2 pc_sel",  32'(bus.pc_sel),  32'd0);
      check("rst2 pending", 32'(bus.pending), 32'd0);
      next_cycle();

      // Randomized traffic
      for (int i = 0; i < 2000; i++) begin
         rst = ($urandom_range(199) == 0);
         set_in(($urandom_range(9) < 4),
                ($urandom_range(9) < 1), $urandom(),
                ($urandom_range(9) < 3), $urandom(),
                ($urandom_range(9) < 3), $urandom());
         next_cycle();
      end
      rst = 1'b0;
      set_in(0, 0, 0, 0, 0, 0, 0);
      next_cycle();

      // Counter: three redirects, then full wrap
      rst = 1'b1;
      next_cycle();
      rst = 1'b0;
      set_in(0, 0, 0, 1, 32'h100, 0, 0);
      for (int i = 0; i < 3; i++) next_cycle();
      set_in(0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
`ifdef REDIRECT_CNT_EN
      check("count3", 32'(bus.redir_count), 32'd3);
      next_cycle();
      rst = 1'b1;
      next_cycle();
      rst = 1'b0;
      set_in(0, 0, 0, 1, 32'h200, 0, 0);
      for (int i = 0; i < (1 << CNT_W); i++) next_cycle();
      set_in(0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      check("count wrap", 32'(bus.redir_count), 32'd0);
`else
      check("count off", 32'(bus.redir_count), 32'd0);
`endif
      next_cycle();
      next_cycle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
